signed_normalizer_pipe: RTL and testbench
=========================================

Name: signed_normalizer_pipe

Overview:
- Pipelined, parametrised leading-sign / leading-zero normaliser with valid/ready handshakes.
- Per transaction, left-shifts the operand until it is normalised and reports the shift count:
  - signed mode: the sign bit and the next bit differ;
  - unsigned mode: the MSB is 1.
- Sits in front of the signed integer divider's iteration core, normalising dividend/divisor.
- Carries a sideband tag so the divider can match results to requests.

Parameters:
- WIDTH, 32: operand width. Power of two, 4..64; elaboration error otherwise.
- TAG_W, 4: sideband tag width, passed through unchanged.
- SHW, $clog2(WIDTH): derived, not overridable. Shift-count width and number of pipeline stages.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_data  in  WIDTH  operand
- in_signed  in  1  1 = signed (sign-bit) normalisation, 0 = unsigned (leading-zero)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready; result retires when out_valid & out_ready
- out_data  out  WIDTH  normalised operand
- out_shift  out  SHW  left-shift amount applied
- out_zero  out  1  operand was exactly 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits clear, so out_valid=0;
  - out_data, out_shift, out_zero and out_tag = 0;
  - in_ready = 1 one cycle after release.
- Pipeline: SHW register stages. Stage i (i=0..SHW-1) tests step k = 2^(SHW-1-i), i.e. stages 16,8,4,2,1 for WIDTH=32.
  - Signed mode: if the top k+1 bits of the running value are all equal, shift left by k (zero fill) and add k to the count.
  - Unsigned mode: if the top k bits are all zero, shift left by k and add k.
- Each stage register holds: valid, value, count, signed flag, zero flag, tag.
- The zero flag is computed from in_data at stage 0.
- Latency: exactly SHW cycles from the accept edge to out_valid when there is no stall. Throughput: 1 per cycle.
- Flow control: global stall.
  - advance = ~out_valid | out_ready.
  - in_ready = advance, combinational.
  - All stages load together only on advance; bubbles do not collapse.
  - A stage whose predecessor is invalid loads valid=0 and leaves its data don't-care.
- Holding: while out_valid & ~out_ready, all out_* hold stable and in_ready=0.
- Boundary results (WIDTH=32):
  - Zero input, either mode: shift WIDTH-1, out_data 0, out_zero 1.
  - All-ones input, signed: shift WIDTH-1, out_data = MSB-only (0x80000000), out_zero 0.
  - Already-normalised input (e.g. 0x40000000 or 0x80000000 signed, 0x80000000 unsigned): shift 0, data unchanged.
- Width rule: the count never exceeds WIDTH-1, because the step sum is 2^SHW-1. No saturation logic is needed.
- Simultaneous accept and retire in one cycle is legal and sustains full throughput.
- Reset mid-flight drops every in-flight transaction; none reappears after release.

Decomposition:
- Shared divider package holds:
  - localparam helper for SHW;
  - stage-payload struct typedef (valid, value, count, signed flag, zero flag, tag);
  - constant NORM_MAX_WIDTH=64.
- One natural sub-module: norm_stage. It is a parametrised on step k and contains one compare / conditional shift / count-add plus its register with enable. It is instantiated SHW times in a generate loop.
- Top level holds only the handshake (advance) logic and output mapping.

Test Plan:
- Signed 0x00001234, tag 3 -> after 5 cycles: out_data 0x48D00000, out_shift 18, out_zero 0, out_tag 3.
- Unsigned 0x00001234 -> out_data 0x91A00000, shift 19. Signed 0xFFFFF000 -> out_data 0x80000000, shift 19.
- Boundary cases:
  - signed 0 -> out_data 0, shift 31, zero 1;
  - signed 0xFFFFFFFF -> out_data 0x80000000, shift 31, zero 0;
  - signed 0x40000000 -> shift 0, unchanged;
  - unsigned 0x80000000 -> shift 0, unchanged.
- Stream of 8 back-to-back random operands with tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model.
- out_ready held low 4 cycles with the pipe full -> in_ready=0, out_* stable throughout; release -> no loss or duplication, order preserved.
- Assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 immediately (async). After release, the next accepted operand is the first result seen.

Source files
------------

// File: rtl/signed_normalizer_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signed_normalizer_pipe_pkg
// Brief    : Shared divider types: normaliser stage payload and size helpers.
// Revision : 1.0
// ============================================================================
package signed_normalizer_pipe_pkg;

    localparam int NORM_MAX_WIDTH = 64;
    localparam int NORM_MAX_TAG_W = 16;
    localparam int NORM_CNT_W     = $clog2(NORM_MAX_WIDTH);

    function automatic int norm_shw(input int width);
        return $clog2(width);
    endfunction

    // Operand is held MSB-aligned in the widest field, so one stage body
    // serves every WIDTH and the bits below the operand stay zero.
    typedef struct packed {
        logic                      valid;
        logic [NORM_MAX_WIDTH-1:0] value;
        logic [NORM_CNT_W-1:0]     count;
        logic                      is_signed;
        logic                      zero;
        logic [NORM_MAX_TAG_W-1:0] tag;
    } norm_payload_t;

endpackage
`default_nettype wire

// File: rtl/signed_normalizer_pipe_norm_stage.sv
`default_nettype none
// ============================================================================
// Module   : norm_stage
// Brief    : One normaliser step of size K: test, conditional shift, count add.
// Revision : 1.0
// ============================================================================
module norm_stage
    import signed_normalizer_pipe_pkg::*;
#(
    parameter int K = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  norm_payload_t d_i,
    output norm_payload_t q_o
);

    norm_payload_t payload_d;
    norm_payload_t payload_q;
    logic [K:0]    w_top_s;
    logic [K-1:0]  w_top_u;
    logic          w_hit;

    always_comb begin
        w_top_s   = d_i.value[NORM_MAX_WIDTH-1 -: K+1];
        w_top_u   = d_i.value[NORM_MAX_WIDTH-1 -: K];
        // Signed: K+1 equal top bits mean K redundant sign bits can go.
        w_hit     = d_i.is_signed ? ((w_top_s == '0) || (w_top_s == '1))
                                  : (w_top_u == '0);
        payload_d = d_i;
        if (w_hit) begin
            payload_d.value = d_i.value << K;
            payload_d.count = d_i.count + NORM_CNT_W'(K);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q <= '0;
        end else if (en_i) begin
            payload_q <= payload_d;
        end
    end

    assign q_o = payload_q;

endmodule
`default_nettype wire

// File: rtl/signed_normalizer_pipe.sv
`default_nettype none
// ============================================================================
// Module   : signed_normalizer_pipe
// Brief    : Pipelined leading-sign / leading-zero normaliser, global stall.
// Revision : 1.0
// ============================================================================
module signed_normalizer_pipe
    import signed_normalizer_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int SHW   = norm_shw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (WIDTH < 4 || WIDTH > NORM_MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("signed_normalizer_pipe: WIDTH must be a power of two in 4..64");
        end
        if (TAG_W < 1 || TAG_W > NORM_MAX_TAG_W) begin : g_bad_tag
            $error("signed_normalizer_pipe: TAG_W must be in 1..16");
        end
    endgenerate

    norm_payload_t w_in;
    norm_payload_t w_pipe [0:SHW];
    logic          w_advance;
    logic          w_unused;

    assign w_advance = ~w_pipe[SHW].valid | out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_in           = '0;
        w_in.valid     = in_valid;
        w_in.value     = NORM_MAX_WIDTH'(in_data) << (NORM_MAX_WIDTH - WIDTH);
        w_in.is_signed = in_signed;
        w_in.zero      = (in_data == '0);
        w_in.tag       = NORM_MAX_TAG_W'(in_tag);
    end

    assign w_pipe[0] = w_in;

    // Steps run largest first: WIDTH/2, WIDTH/4, ..., 1.
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            norm_stage #(
                .K (1 << (SHW - 1 - gi))
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en_i (w_advance),
                .d_i  (w_pipe[gi]),
                .q_o  (w_pipe[gi+1])
            );
        end
    endgenerate

    assign out_valid = w_pipe[SHW].valid;
    assign out_data  = w_pipe[SHW].value[NORM_MAX_WIDTH-1 -: WIDTH];
    assign out_shift = w_pipe[SHW].count[SHW-1:0];
    assign out_zero  = w_pipe[SHW].zero;
    assign out_tag   = w_pipe[SHW].tag[TAG_W-1:0];
    assign w_unused  = ^w_pipe[SHW];

endmodule
`default_nettype wire

// File: tb/tb_signed_normalizer_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_normalizer_pipe
// Brief    : Self-checking bench with a shift-one-bit-at-a-time reference.
// Revision : 1.0
// ============================================================================
module tb_signed_normalizer_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_signed;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_shift;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    signed_normalizer_pipe #(
        .WIDTH (W),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [W-1:0]  data;
        int            shift;
        logic          zero;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   lat_on = 1'b0;

    // Reference: shift one bit at a time while the operand is not yet normalised.
    function automatic exp_t ref_norm(logic [W-1:0] d, logic s, logic [TW-1:0] t);
        exp_t         e;
        logic [W-1:0] v  = d;
        int           sh = 0;
        while (sh < W - 1 && (s ? (v[W-1] == v[W-2]) : !v[W-1])) begin
            v  = v << 1;
            sh = sh + 1;
        end
        e.data  = v;
        e.shift = sh;
        e.zero  = (d == '0);
        e.tag   = t;
        e.acc   = cyc;
        return e;
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, observe handshakes 1 unit later.
    task automatic step(logic v, logic [W-1:0] d, logic s, logic [TW-1:0] t, logic rdy);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        in_signed = s;
        in_tag    = t;
        out_ready = rdy;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("data",  64'(out_data),  64'(e.data));
                check_eq("shift", 64'(out_shift), 64'(e.shift));
                check_eq("zero",  64'(out_zero),  64'(e.zero));
                check_eq("tag",   64'(out_tag),   64'(e.tag));
                if (lat_on) check_eq("latency", 64'(cyc - e.acc), 64'(SW));
            end
        end
        if (in_valid && in_ready) sb.push_back(ref_norm(d, s, t));
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] r = $urandom >> ($urandom_range(0, W - 1));
        if ($urandom_range(0, 1) == 1) r = ~r;
        return r;
    endfunction

    logic [W-1:0]  snap_data;
    logic [SW-1:0] snap_shift;
    logic          snap_zero;
    logic [TW-1:0] snap_tag;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data",  64'(out_data),  64'd0);
        check_eq("rst_shift", 64'(out_shift), 64'd0);
        check_eq("rst_zero",  64'(out_zero),  64'd0);
        check_eq("rst_tag",   64'(out_tag),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1 check_eq("rdy_after_rst", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed operands including the boundary cases
        lat_on = 1'b1;
        step(1'b1, 32'h0000_1234, 1'b1, 4'd3, 1'b1);
        step(1'b1, 32'h0000_1234, 1'b0, 4'd4, 1'b1);
        step(1'b1, 32'hFFFF_F000, 1'b1, 4'd5, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b1, 4'd6, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 4'd7, 1'b1);
        step(1'b1, 32'h4000_0000, 1'b1, 4'd8, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b0, 4'd9, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b1, 4'd10, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b0, 4'd11, 1'b1);
        step(1'b1, 32'h0000_0001, 1'b0, 4'd12, 1'b1);
        idle(8);

        // Eight back-to-back random operands, tags 0..7
        for (int i = 0; i < 8; i++)
            step(1'b1, rnd_operand(), 1'($urandom_range(0, 1)), TW'(i), 1'b1);
        idle(8);

        // Stall with the pipe full
        lat_on = 1'b0;
        for (int i = 0; i < 6; i++)
            step(1'b1, rnd_operand(), 1'($urandom_range(0, 1)), TW'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = rnd_operand();
            in_signed = 1'b1;
            in_tag    = 4'hF;
            out_ready = 1'b0;
            #1;
            check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            if (i == 0) begin
                check_eq("stall_valid", 64'(out_valid), 64'd1);
                snap_data  = out_data;
                snap_shift = out_shift;
                snap_zero  = out_zero;
                snap_tag   = out_tag;
            end else begin
                check_eq("stall_data",  64'(out_data),  64'(snap_data));
                check_eq("stall_shift", 64'(out_shift), 64'(snap_shift));
                check_eq("stall_zero",  64'(out_zero),  64'(snap_zero));
                check_eq("stall_tag",   64'(out_tag),   64'(snap_tag));
                check_eq("stall_vhold", 64'(out_valid), 64'd1);
            end
            cyc++;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            step(1'b1, rnd_operand(), 1'($urandom_range(0, 1)), TW'(8 + i), 1'b1);
        idle(10);
        check_eq("stall_drain", 64'(sb.size()), 64'd0);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, rnd_operand(), 1'b1, TW'(i), 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        #1 check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst_data",  64'(out_data),  64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rdy_after_rst2", 64'(in_ready), 64'd1);
        @(negedge clk);
        lat_on = 1'b1;
        step(1'b1, 32'h0000_00F0, 1'b1, 4'hA, 1'b1);
        idle(8);
        check_eq("post_rst_drain", 64'(sb.size()), 64'd0);

        // Random valid/ready traffic
        lat_on = 1'b0;
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), rnd_operand(), 1'($urandom_range(0, 1)),
                 TW'($urandom), 1'($urandom_range(0, 3) != 0));
        idle(12);
        check_eq("final_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
